ifu_fetch: RTL

- Instruction fetch unit: owns the PC, issues fetch requests to instruction memory and returns 32-bit instructions.
- Presents instruction plus PC to the decode stage over a valid/ready handshake; it is the producer for the decoder's instruction input.
- Accepts a redirect (jump/branch target) from execute and discards any stale fetch already in flight.
- One outstanding fetch at a time; no prediction.

---
 rtl/ifu_fetch.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/ifu_fetch.sv
// ifu_fetch: owns the PC, one outstanding imem fetch, valid/ready to decode.
// Optional IFU_MISALIGN_CHK_EN reports misaligned redirect targets instead of fetching.
module ifu_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int          INST_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [63:0]       redirect_pc,
    output logic              imem_req_valid,
    output logic [63:0]       imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [INST_W-1:0] if_inst,
`ifdef IFU_MISALIGN_CHK_EN
    output logic              if_misalign,
`endif
    output logic [63:0]       if_pc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_HALT
    } state_t;

    state_t            state_q, state_d;
    logic [63:0]       pc_q, pc_d;
    logic [63:0]       ipc_q, ipc_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              drop_q, drop_d;
    logic              mis_q, mis_d;
    logic              mis_redir;
    logic [63:0]       redir_tgt;

    assign redir_tgt = {redirect_pc[63:2], 2'b00};

`ifdef IFU_MISALIGN_CHK_EN
    assign mis_redir = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
    logic unused_lo;
    assign unused_lo = ^redirect_pc[1:0];
    assign mis_redir = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ipc_q   <= '0;
            inst_q  <= '0;
            drop_q  <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ipc_q   <= ipc_d;
            inst_q  <= inst_d;
            drop_q  <= drop_d;
            mis_q   <= mis_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ipc_d   = ipc_q;
        inst_d  = inst_q;
        drop_d  = drop_q;
        mis_d   = mis_q;
        if (mis_redir) begin
            // Misaligned target: report it to decode, never fetch it
            state_d = S_HOLD;
            pc_d    = redirect_pc;
            ipc_d   = redirect_pc;
            inst_d  = '0;
            drop_d  = 1'b0;
            mis_d   = 1'b1;
        end else if (redirect_valid) begin
            pc_d    = redir_tgt;
            drop_d  = 1'b0;
            mis_d   = 1'b0;
            state_d = S_REQ;
            unique case (state_q)
                S_REQ: begin
                    // Old-PC request still goes out; its response must be eaten
                    if (imem_req_ready) begin
                        state_d = S_WAIT;
                        drop_d  = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (!imem_rsp_valid) begin
                        state_d = S_WAIT;
                        drop_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end else begin
            unique case (state_q)
                S_IDLE: state_d = S_REQ;
                S_REQ: begin
                    if (imem_req_ready) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = S_REQ;
                        end else begin
                            inst_d  = imem_rsp_data;
                            ipc_d   = pc_q;
                            pc_d    = pc_q + 64'd4;
                            state_d = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (if_ready) begin
                        state_d = mis_q ? S_HALT : S_REQ;
                        mis_d   = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_req_valid = (state_q == S_REQ);
    assign imem_req_addr  = pc_q;
    assign if_valid       = (state_q == S_HOLD);
    assign if_inst        = inst_q;
    assign if_pc          = ipc_q;
`ifdef IFU_MISALIGN_CHK_EN
    assign if_misalign    = mis_q;
`endif

endmodule
